// File: rtl/traffic_pkg.sv
// Shared lamp encodings and phase enumeration for the intersection scheduler.
// Lamp vectors are {red, yellow, green}; FLASH is declared even when night mode is not built.
package traffic_pkg;

    typedef logic [2:0] lamp_t;

    localparam lamp_t LAMP_RED    = 3'b100;
    localparam lamp_t LAMP_YELLOW = 3'b010;
    localparam lamp_t LAMP_GREEN  = 3'b001;
    localparam lamp_t LAMP_OFF    = 3'b000;

    typedef enum logic [2:0] {
        S1_GREEN,
        S1_YELLOW,
        ALL_RED,
        S2_GREEN,
        S2_YELLOW,
        PED_WALK,
        FLASH
    } phase_e;

    typedef enum logic {
        STREET1 = 1'b0,
        STREET2 = 1'b1
    } street_e;

endpackage

// File: rtl/tick_prescaler.sv
// One-cycle tick every CLK_FREQ cycles; clr restarts the count so the first tick lands CLK_FREQ cycles later.
// No backpressure: tick is a free-running strobe.
module tick_prescaler #(
    parameter int CLK_FREQ = 25_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic tick_o
);

    localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_FREQ - 1);

    logic [PW-1:0] cnt;

    assign tick_o = (cnt == LAST);

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i || tick_o) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PW'(1);
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-driven two-street + pedestrian phase sequencer; 2-cycle input sync, Moore lamp outputs.
// No backpressure. Optional night flashing mode with night_i when TRAFFIC_NIGHT_FLASH_EN is defined.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int CLK_FREQ    = 25_000_000,
    parameter int GREEN_MIN_S = 5,
    parameter int GREEN_MAX_S = 20,
    parameter int YELLOW_S    = 3,
    parameter int ALL_RED_S   = 1,
    parameter int WALK_S      = 6
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] car_i,
    input  logic [1:0] ped_req_i,
`ifdef TRAFFIC_NIGHT_FLASH_EN
    input  logic       night_i,
`endif
    output logic [2:0] street1_o,
    output logic [2:0] street2_o,
    output logic [1:0] walk_o
);

    localparam int TW = $clog2(GREEN_MAX_S + 1);
    typedef logic [TW:0] elapsed_t;

    localparam elapsed_t T_GMIN   = elapsed_t'(GREEN_MIN_S);
    localparam elapsed_t T_GMAX   = elapsed_t'(GREEN_MAX_S);
    localparam elapsed_t T_YELLOW = elapsed_t'(YELLOW_S);
    localparam elapsed_t T_ALLRED = elapsed_t'(ALL_RED_S);
    localparam elapsed_t T_WALK   = elapsed_t'(WALK_S);
    localparam logic [TW-1:0] T_SAT = TW'(GREEN_MAX_S);

    phase_e        state_q, state_d;
    street_e       next_q, next_d;
    logic [TW-1:0] ticks_q;
    elapsed_t      elapsed;
    logic          tick;
    logic          phase_change;
    logic [1:0]    car_meta, car_sync;
    logic [1:0]    ped_meta, ped_sync;
    logic          ped_pending_q;
    logic          ped_demand;
    logic          flash_on;

    tick_prescaler #(
        .CLK_FREQ(CLK_FREQ)
    ) u_prescaler (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clr_i (phase_change),
        .tick_o(tick)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            car_meta <= '0;
            car_sync <= '0;
            ped_meta <= '0;
            ped_sync <= '0;
        end else begin
            car_meta <= car_i;
            car_sync <= car_meta;
            ped_meta <= ped_req_i;
            ped_sync <= ped_meta;
        end
    end

    // Elapsed count including the tick in progress, so an N-tick phase exits on its Nth tick.
    assign elapsed      = {1'b0, ticks_q} + elapsed_t'(1);
    assign ped_demand   = ped_pending_q | (|ped_sync);
    assign phase_change = (state_d != state_q);

`ifdef TRAFFIC_NIGHT_FLASH_EN
    logic night_meta, night_sync;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            night_meta <= 1'b0;
            night_sync <= 1'b0;
            flash_on   <= 1'b0;
        end else begin
            night_meta <= night_i;
            night_sync <= night_meta;
            if (state_d == FLASH && state_q != FLASH) begin
                flash_on <= 1'b1;
            end else if (state_q == FLASH && tick) begin
                flash_on <= ~flash_on;
            end
        end
    end
`else
    assign flash_on = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        next_d  = next_q;
        case (state_q)
            S1_GREEN: begin
                if (tick && elapsed >= T_GMIN && (car_sync[1] || ped_demand)
                    && (!car_sync[0] || elapsed >= T_GMAX)) begin
                    state_d = S1_YELLOW;
                end
            end
            S2_GREEN: begin
                if (tick && elapsed >= T_GMIN && (car_sync[0] || ped_demand)
                    && (!car_sync[1] || elapsed >= T_GMAX)) begin
                    state_d = S2_YELLOW;
                end
            end
            S1_YELLOW: begin
                if (tick && elapsed >= T_YELLOW) begin
                    state_d = ALL_RED;
                    next_d  = STREET2;
                end
            end
            S2_YELLOW: begin
                if (tick && elapsed >= T_YELLOW) begin
                    state_d = ALL_RED;
                    next_d  = STREET1;
                end
            end
            ALL_RED: begin
                if (tick && elapsed >= T_ALLRED) begin
                    if (ped_pending_q) begin
                        state_d = PED_WALK;
                    end else if (next_q == STREET2) begin
                        state_d = S2_GREEN;
                    end else begin
                        state_d = S1_GREEN;
                    end
                end
            end
            PED_WALK: begin
                if (tick && elapsed >= T_WALK) begin
                    state_d = ALL_RED;
                end
            end
            FLASH: begin
                // Only held while night is asserted; leaving always clears through street1.
                state_d = ALL_RED;
                next_d  = STREET1;
            end
            default: state_d = S1_GREEN;
        endcase
`ifdef TRAFFIC_NIGHT_FLASH_EN
        if (night_sync) begin
            state_d = FLASH;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= S1_GREEN;
            next_q        <= STREET2;
            ticks_q       <= '0;
            ped_pending_q <= 1'b0;
        end else begin
            state_q <= state_d;
            next_q  <= next_d;
            if (phase_change) begin
                ticks_q <= '0;
            end else if (tick && ticks_q != T_SAT) begin
                ticks_q <= elapsed[TW-1:0];
            end
            // Walk entry beats a same-cycle press; presses during walk or flash are dropped.
            if ((state_d == PED_WALK && state_q != PED_WALK) || state_q == FLASH) begin
                ped_pending_q <= 1'b0;
            end else if (state_q != PED_WALK && (|ped_sync)) begin
                ped_pending_q <= 1'b1;
            end
        end
    end

    always_comb begin
        street1_o = LAMP_RED;
        street2_o = LAMP_RED;
        walk_o    = 2'b00;
        case (state_q)
            S1_GREEN:  street1_o = LAMP_GREEN;
            S1_YELLOW: street1_o = LAMP_YELLOW;
            S2_GREEN:  street2_o = LAMP_GREEN;
            S2_YELLOW: street2_o = LAMP_YELLOW;
            PED_WALK:  walk_o    = 2'b11;
            FLASH: begin
                street1_o = flash_on ? LAMP_YELLOW : LAMP_OFF;
                street2_o = flash_on ? LAMP_YELLOW : LAMP_OFF;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler with CLK_FREQ=1 (one tick per cycle).
// Cycle 0 is the first cycle after reset release; outputs are sampled on the falling edge.
module tb_traffic_phase_scheduler;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] O = 3'b000;

    typedef struct {
        int         cyc;
        logic [1:0] car;
        logic [1:0] ped;
        logic [2:0] s1;
        logic [2:0] s2;
        logic [1:0] walk;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] car = 2'b00;
    logic [1:0] ped = 2'b00;
    logic       night = 1'b0;
    logic [2:0] street1, street2;
    logic [1:0] walk;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    traffic_phase_scheduler #(
        .CLK_FREQ(1)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .car_i    (car),
        .ped_req_i(ped),
`ifdef TRAFFIC_NIGHT_FLASH_EN
        .night_i  (night),
`endif
        .street1_o(street1),
        .street2_o(street2),
        .walk_o   (walk)
    );

    always #5 clk = ~clk;

    // Safety: the two streets are never both shown a non-red aspect (flash shows both yellow/off).
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            assert (street1 == R || street2 == R
`ifdef TRAFFIC_NIGHT_FLASH_EN
                    || (street1 == street2 && (street1 == Y || street1 == O))
`endif
                   ) else begin
                errors++;
                $display("FAIL both_open: street1=%b street2=%b (one must be 100)", street1, street2);
            end
        end
    end

    function automatic vec_t v(int c, logic [1:0] cr, logic [1:0] pd,
                               logic [2:0] e1, logic [2:0] e2, logic [1:0] ew);
        vec_t r;
        r.cyc = c; r.car = cr; r.ped = pd; r.s1 = e1; r.s2 = e2; r.walk = ew;
        return r;
    endfunction

    task automatic check(string name, logic [2:0] e1, logic [2:0] e2, logic [1:0] ew);
        checks++;
        if (street1 !== e1 || street2 !== e2 || walk !== ew) begin
            errors++;
            $display("FAIL %s: got s1=%b s2=%b walk=%b, expected s1=%b s2=%b walk=%b",
                     name, street1, street2, walk, e1, e2, ew);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        car   = 2'b00;
        ped   = 2'b00;
        night = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cur;

        // Scenario: car on street2 only -> street1 yields after minimum green.
        tbl.push_back(v(0,  2'b10, 2'b00, G, R, 2'b00));
        tbl.push_back(v(4,  2'b10, 2'b00, G, R, 2'b00));
        tbl.push_back(v(5,  2'b10, 2'b00, Y, R, 2'b00));
        tbl.push_back(v(7,  2'b10, 2'b00, Y, R, 2'b00));
        tbl.push_back(v(8,  2'b10, 2'b00, R, R, 2'b00));
        tbl.push_back(v(9,  2'b10, 2'b00, R, G, 2'b00));
        tbl.push_back(v(40, 2'b10, 2'b00, R, G, 2'b00));
        // Scenario: both streets loaded -> maximum green each way.
        tbl.push_back(v(0,  2'b11, 2'b00, G, R, 2'b00));
        tbl.push_back(v(19, 2'b11, 2'b00, G, R, 2'b00));
        tbl.push_back(v(20, 2'b11, 2'b00, Y, R, 2'b00));
        tbl.push_back(v(22, 2'b11, 2'b00, Y, R, 2'b00));
        tbl.push_back(v(23, 2'b11, 2'b00, R, R, 2'b00));
        tbl.push_back(v(24, 2'b11, 2'b00, R, G, 2'b00));
        tbl.push_back(v(43, 2'b11, 2'b00, R, G, 2'b00));
        tbl.push_back(v(44, 2'b11, 2'b00, R, Y, 2'b00));
        tbl.push_back(v(47, 2'b11, 2'b00, R, R, 2'b00));
        tbl.push_back(v(48, 2'b11, 2'b00, G, R, 2'b00));
        // Scenario: pedestrian press at 2, second press during walk is ignored.
        tbl.push_back(v(0,  2'b00, 2'b00, G, R, 2'b00));
        tbl.push_back(v(2,  2'b00, 2'b01, G, R, 2'b00));
        tbl.push_back(v(3,  2'b00, 2'b00, G, R, 2'b00));
        tbl.push_back(v(4,  2'b00, 2'b00, G, R, 2'b00));
        tbl.push_back(v(5,  2'b00, 2'b00, Y, R, 2'b00));
        tbl.push_back(v(7,  2'b00, 2'b00, Y, R, 2'b00));
        tbl.push_back(v(8,  2'b00, 2'b00, R, R, 2'b00));
        tbl.push_back(v(9,  2'b00, 2'b00, R, R, 2'b11));
        tbl.push_back(v(11, 2'b00, 2'b01, R, R, 2'b11));
        tbl.push_back(v(12, 2'b00, 2'b00, R, R, 2'b11));
        tbl.push_back(v(14, 2'b00, 2'b00, R, R, 2'b11));
        tbl.push_back(v(15, 2'b00, 2'b00, R, R, 2'b00));
        tbl.push_back(v(16, 2'b00, 2'b00, R, G, 2'b00));
        tbl.push_back(v(40, 2'b00, 2'b00, R, G, 2'b00));

        cur = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].cyc == 0) begin
                do_reset();
                cur = 0;
            end else begin
                while (cur < tbl[i].cyc) begin
                    step();
                    cur++;
                end
            end
            car = tbl[i].car;
            ped = tbl[i].ped;
            @(negedge clk);
            check($sformatf("vec%0d_cyc%0d", i, tbl[i].cyc), tbl[i].s1, tbl[i].s2, tbl[i].walk);
        end

        // Idle intersection rests in street1 green for 200 cycles.
        do_reset();
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            check($sformatf("idle_cyc%0d", c), G, R, 2'b00);
            step();
        end

        // Reset pulse during street2 yellow returns straight to street1 green.
        do_reset();
        car = 2'b10;
        for (int c = 0; c < 9; c++) step();
        car = 2'b01;
        for (int c = 9; c < 14; c++) step();
        @(negedge clk);
        check("pre_reset_s2_yellow", R, Y, 2'b00);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_state", G, R, 2'b00);

`ifdef TRAFFIC_NIGHT_FLASH_EN
        // Night flash mid-green, then release through one all-red cycle.
        do_reset();
        for (int c = 0; c < 3; c++) step();
        night = 1'b1;
        for (int c = 3; c < 6; c++) step();
        @(negedge clk);
        check("flash_on_6", Y, Y, 2'b00);
        step();
        @(negedge clk);
        check("flash_off_7", O, O, 2'b00);
        step();
        @(negedge clk);
        check("flash_on_8", Y, Y, 2'b00);
        step();
        night = 1'b0;
        for (int c = 9; c < 12; c++) step();
        @(negedge clk);
        check("flash_exit_allred_12", R, R, 2'b00);
        step();
        @(negedge clk);
        check("flash_exit_s1_13", G, R, 2'b00);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
